// File: rtl/mem_responder.sv
// Byte-addressed RAM answering the CU's MOV/RW/typeData/MOC four-phase memory handshake.
// MOC rises WAIT_CYC+1 edges after MOV is sampled; the CU holds MOV until it sees MOC, and MOC holds until MOV drops.
module mem_responder #(
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic        typeData,
    input  logic [31:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        MOC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_moc;
    logic                w_moc_nxt;
    logic                w_latch;
    logic                w_exec;

    logic                r_rw;
    logic                r_type;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_din;
    logic [31:0]         r_dout;

    logic [7:0]          r_mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]   w_b0;
    logic [ADDR_W-1:0]   w_b1;
    logic [ADDR_W-1:0]   w_b2;
    logic [ADDR_W-1:0]   w_b3;
    logic [31:0]         w_rd_data;
    logic                w_unused_addr;

    // Upper address bits are dropped so accesses wrap within the RAM.
    assign w_unused_addr = ^addr[31:ADDR_W];

    assign w_b0 = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_b1 = {r_addr[ADDR_W-1:2], 2'b01};
    assign w_b2 = {r_addr[ADDR_W-1:2], 2'b10};
    assign w_b3 = {r_addr[ADDR_W-1:2], 2'b11};

    assign w_rd_data = r_type ? {r_mem[w_b0], r_mem[w_b1], r_mem[w_b2], r_mem[w_b3]}
                              : {24'h0, r_mem[r_addr]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_moc_nxt   = r_moc;
        w_latch     = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (MOV) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_CYC);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_exec      = 1'b1;
                    w_moc_nxt   = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (!MOV) begin
                    w_moc_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_moc_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_moc   <= 1'b0;
            r_dout  <= 32'h0;
            r_rw    <= 1'b0;
            r_type  <= 1'b0;
            r_addr  <= '0;
            r_din   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_moc   <= w_moc_nxt;
            if (w_latch) begin
                r_rw   <= RW;
                r_type <= typeData;
                r_addr <= addr[ADDR_W-1:0];
                r_din  <= dataIn;
            end
            if (w_exec && r_rw) begin
                r_dout <= w_rd_data;
            end
        end
    end

    // RAM contents survive CLR; only an executing write touches them.
    always_ff @(posedge CLK) begin
        if (!CLR && w_exec && !r_rw) begin
            if (r_type) begin
                r_mem[w_b0] <= r_din[31:24];
                r_mem[w_b1] <= r_din[23:16];
                r_mem[w_b2] <= r_din[15:8];
                r_mem[w_b3] <= r_din[7:0];
            end else begin
                r_mem[r_addr] <= r_din[7:0];
            end
        end
    end

    assign dataOut = r_dout;
    assign MOC     = r_moc;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-array reference RAM predicts read data,
// expected words are queued at request time and popped when MOC reports completion.
module tb_mem_responder;

    localparam int ADDR_W   = 9;
    localparam int WAIT_CYC = 2;
    localparam int MAX_WAIT = 20;

    logic        CLK;
    logic        CLR;
    logic        MOV;
    logic        RW;
    logic        typeData;
    logic [31:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        MOC;

    int checks;
    int errors;

    logic [7:0]  mdl [0:(2**ADDR_W)-1];
    logic [31:0] exp_q [$];

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .MOV      (MOV),
        .RW       (RW),
        .typeData (typeData),
        .addr     (addr),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .MOC      (MOC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mdl_read(input logic ty, input logic [31:0] a);
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W-1:0] base;
        idx  = a[ADDR_W-1:0];
        base = {idx[ADDR_W-1:2], 2'b00};
        if (ty) return {mdl[base], mdl[base+1], mdl[base+2], mdl[base+3]};
        return {24'h0, mdl[idx]};
    endfunction

    task automatic mdl_write(input logic ty, input logic [31:0] a, input logic [31:0] d);
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W-1:0] base;
        idx  = a[ADDR_W-1:0];
        base = {idx[ADDR_W-1:2], 2'b00};
        if (ty) begin
            mdl[base]   = d[31:24];
            mdl[base+1] = d[23:16];
            mdl[base+2] = d[15:8];
            mdl[base+3] = d[7:0];
        end else begin
            mdl[idx] = d[7:0];
        end
    endtask

    // One full handshake. hold = extra cycles MOV stays high after MOC; drop_early releases MOV right after the sample.
    task automatic access(input logic rw, input logic ty, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit drop_early);
        int          n;
        logic [31:0] prev_dout;
        logic [31:0] exp_v;
        prev_dout = dataOut;
        if (rw) exp_q.push_back(mdl_read(ty, a));
        else    mdl_write(ty, a, d);
        MOV = 1'b1; RW = rw; typeData = ty; addr = a; dataIn = d;
        tick();
        if (drop_early) begin
            MOV = 1'b0; RW = ~rw; addr = 32'hFFFF_FFFF; dataIn = 32'h0;
        end
        n = 0;
        while (!MOC && n < MAX_WAIT) begin
            tick();
            n++;
        end
        checks++;
        if (n != WAIT_CYC + 1) begin
            errors++;
            $display("FAIL latency addr=%h: got %0d edges, want %0d", a, n, WAIT_CYC + 1);
        end
        if (rw) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (dataOut !== exp_v) begin
                errors++;
                $display("FAIL read_data addr=%h ty=%0d: got %h, want %h", a, ty, dataOut, exp_v);
            end
        end else begin
            checks++;
            if (dataOut !== prev_dout) begin
                errors++;
                $display("FAIL write_keeps_dout addr=%h: got %h, want %h", a, dataOut, prev_dout);
            end
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (MOC !== 1'b1) begin
                errors++;
                $display("FAIL moc_hold cycle %0d: got %b, want 1", i, MOC);
            end
        end
        MOV = 1'b0;
        tick();
        checks++;
        if (MOC !== 1'b0) begin
            errors++;
            $display("FAIL moc_release addr=%h: got %b, want 0", a, MOC);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1; MOV = 1'b0; RW = 1'b0; typeData = 1'b0; addr = 32'h0; dataIn = 32'h0;
        tick();
        tick();
        CLR = 1'b0;
        tick();
        checks++;
        if (MOC !== 1'b0) begin errors++; $display("FAIL reset_moc: got %b, want 0", MOC); end
        checks++;
        if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h, want 0", dataOut); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (MOC !== 1'b0) begin errors++; $display("FAIL idle_moc cycle %0d: got %b, want 0", i, MOC); end
        end
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, 32'h10, 32'hE7D1_2000, 0, 1'b0);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0, 1'b0);
    endtask

    task automatic test_byte();
        for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 32'h10 + 32'(i), 32'h0, 0, 1'b0);
        access(1'b0, 1'b0, 32'h12, 32'h0000_00AB, 0, 1'b0);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0, 1'b0);
    endtask

    task automatic test_alias();
        access(1'b1, 1'b1, 32'h13, 32'h0, 0, 1'b0);
        access(1'b1, 1'b1, 32'h210, 32'h0, 0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0205, 32'h0000_0042, 0, 1'b0);
        access(1'b1, 1'b0, 32'h5, 32'h0, 0, 1'b0);
    endtask

    task automatic test_handshake();
        logic [31:0] hold_dout;
        access(1'b1, 1'b1, 32'h10, 32'h0, 4, 1'b0);
        hold_dout = dataOut;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (MOC !== 1'b0 || dataOut !== hold_dout) begin
                errors++;
                $display("FAIL no_second_access cycle %0d: moc=%b dout=%h, want 0 %h", i, MOC, dataOut, hold_dout);
            end
        end
        access(1'b0, 1'b0, 32'h30, 32'h0000_005A, 0, 1'b1);
        access(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0, 1'b1);
    endtask

    task automatic test_abort();
        access(1'b0, 1'b1, 32'h20, 32'h1122_3344, 0, 1'b0);
        MOV = 1'b1; RW = 1'b0; typeData = 1'b1; addr = 32'h20; dataIn = 32'hDEAD_BEEF;
        tick();
        tick();
        CLR = 1'b1; MOV = 1'b0;
        tick();
        CLR = 1'b0;
        checks++;
        if (MOC !== 1'b0 || dataOut !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: moc=%b dout=%h, want 0 00000000", MOC, dataOut);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (MOC !== 1'b0) begin errors++; $display("FAIL abort_moc cycle %0d: got %b, want 0", i, MOC); end
        end
        access(1'b1, 1'b1, 32'h20, 32'h0, 0, 1'b0);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        CLR = 1'b1; MOV = 1'b0; RW = 1'b0; typeData = 1'b0; addr = 32'h0; dataIn = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_alias();
        test_handshake();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
